// File: rtl/write_arbiter.sv
// rtl/write_arbiter.sv - assembles UART payload bytes into one DMI write word
module write_arbiter #(
  parameter int                   IRLENGTH    = 5,
  parameter int                   CMDLENGTH   = 3,
  parameter int                   DRLENGTH    = 41,
  parameter int                   TIMEOUT     = 1024,
  parameter logic [CMDLENGTH-1:0] CMD_WRITE   = CMDLENGTH'(2),
  parameter logic [CMDLENGTH-1:0] CMD_RESET   = CMDLENGTH'(3),
  parameter logic [IRLENGTH-1:0]  ADDR_IDCODE = IRLENGTH'(1)
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 VALID_I,
  output logic                 READY_O,
  input  logic [CMDLENGTH-1:0] COMMAND_I,
  input  logic [IRLENGTH-1:0]  ADDRESS_I,
  input  logic                 RX_VALID_I,
  input  logic [7:0]           RX_DATA_I,
  output logic                 RX_READ_O,
  output logic                 DMI_VALID_O,
  input  logic                 DMI_READY_I,
  output logic [IRLENGTH-1:0]  DMI_ADDRESS_O,
  output logic [DRLENGTH-1:0]  DMI_DATA_O,
  output logic                 ERROR_O
);

  localparam int NBYTES = (DRLENGTH + 7) / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam int TCNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_WRITE, ST_ACK} state_e;

  state_e              r_state;
  state_e              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [DRLENGTH-1:0] r_data;
  logic [IRLENGTH-1:0] r_addr;

  logic                w_accept_write;
  logic                w_accept_reset;
  logic                w_byte;
  logic                w_last;
  logic                w_timeout;
  logic [DRLENGTH-1:0] w_shift;
  logic [DRLENGTH-1:0] w_mask;
  logic [DRLENGTH-1:0] w_cap_data;

  assign w_accept_write = (r_state == ST_IDLE) && VALID_I && (COMMAND_I == CMD_WRITE);
  assign w_accept_reset = (r_state == ST_IDLE) && VALID_I && (COMMAND_I == CMD_RESET);
  assign w_byte         = (r_state == ST_COLLECT) && RX_VALID_I;
  assign w_last         = (r_cnt == CNT_W'(NBYTES - 1));
  assign w_timeout      = (r_state == ST_COLLECT) && !RX_VALID_I
                          && (r_tcnt == TCNT_W'(TIMEOUT - 1));

  // Byte lane insert; the shift naturally drops bits of the last byte above DRLENGTH-1
  assign w_shift    = DRLENGTH'(RX_DATA_I) << {r_cnt, 3'b000};
  assign w_mask     = DRLENGTH'(8'hFF) << {r_cnt, 3'b000};
  assign w_cap_data = (r_data & ~w_mask) | w_shift;

  assign DMI_ADDRESS_O = r_addr;
  assign DMI_DATA_O    = r_data;

  // State register
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs; READY_O is also forced low while reset is held
  always_comb begin
    w_next      = r_state;
    READY_O     = 1'b0;
    RX_READ_O   = 1'b0;
    DMI_VALID_O = 1'b0;
    ERROR_O     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        READY_O = RST_NI;
        if (w_accept_write) begin
          w_next = ST_COLLECT;
        end else if (w_accept_reset) begin
          w_next = ST_ACK;
        end
      end
      ST_COLLECT: begin
        RX_READ_O = RX_VALID_I;
        if (w_byte && w_last) begin
          w_next = ST_WRITE;
        end else if (w_timeout) begin
          ERROR_O = 1'b1;
          w_next  = ST_ACK;
        end
      end
      ST_WRITE: begin
        DMI_VALID_O = 1'b1;
        if (DMI_READY_I) begin
          w_next = ST_ACK;
        end
      end
      ST_ACK: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Address/data capture plus byte and idle-gap counters
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_cnt  <= '0;
      r_tcnt <= '0;
      r_data <= '0;
      r_addr <= ADDR_IDCODE;
    end else if (w_accept_write) begin
      r_addr <= ADDRESS_I;
      r_data <= '0;
      r_cnt  <= '0;
      r_tcnt <= '0;
    end else if (w_accept_reset) begin
      r_addr <= ADDR_IDCODE;
      r_data <= '0;
    end else if (w_byte) begin
      r_data <= w_cap_data;
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tcnt <= '0;
    end else if (r_state == ST_COLLECT) begin
      r_tcnt <= w_timeout ? '0 : r_tcnt + TCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_write_arbiter.sv
// tb/tb_write_arbiter.sv - self-checking bench for write_arbiter
`timescale 1ns/1ps
module tb_write_arbiter;

  localparam int         TIMEOUT     = 1024;
  localparam int         NBYTES      = 6;
  localparam logic [2:0] CMD_WRITE   = 3'h2;
  localparam logic [2:0] CMD_RESET   = 3'h3;
  localparam logic [2:0] CMD_OTHER   = 3'h5;
  localparam logic [4:0] ADDR_IDCODE = 5'h01;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [2:0]  command;
  logic [4:0]  address;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_read;
  logic        dmi_valid;
  logic        dmi_ready;
  logic [4:0]  dmi_address;
  logic [40:0] dmi_data;
  logic        error;

  int n_pass = 0;
  int n_tot  = 0;

  // Cumulative observations gathered on every falling edge
  int          c_cyc      = 0;
  int          c_valid    = 0;
  int          c_rdy_low  = 0;
  int          c_err      = 0;
  int          c_rxread   = 0;
  int          c_last_rx  = 0;
  int          c_err_cyc  = 0;
  logic [40:0] last_data  = '0;
  logic [4:0]  last_addr  = '0;

  typedef struct {
    bit          col;
    bit          wr;
    bit          ack;
    int          got;
    int          idle;
    logic [47:0] word;
    logic [4:0]  addr;
  } model_t;

  write_arbiter dut (
    .CLK_I         (clk),
    .RST_NI        (rst_n),
    .VALID_I       (valid),
    .READY_O       (ready),
    .COMMAND_I     (command),
    .ADDRESS_I     (address),
    .RX_VALID_I    (rx_valid),
    .RX_DATA_I     (rx_data),
    .RX_READ_O     (rx_read),
    .DMI_VALID_O   (dmi_valid),
    .DMI_READY_I   (dmi_ready),
    .DMI_ADDRESS_O (dmi_address),
    .DMI_DATA_O    (dmi_data),
    .ERROR_O       (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endfunction

  function automatic model_t reset_model();
    model_t r;
    r.col  = 1'b0;
    r.wr   = 1'b0;
    r.ack  = 1'b0;
    r.got  = 0;
    r.idle = 0;
    r.word = '0;
    r.addr = ADDR_IDCODE;
    return r;
  endfunction

  // Transaction-level model: busy while collecting, waiting on the TAP, or in the ack gap
  task automatic compare_loop();
    model_t m;
    model_t n;
    logic   e_ready;
    logic   e_err;
    m = reset_model();
    n = m;
    forever begin
      @(negedge clk);
      if (!rst_n) m = reset_model();
      e_ready = rst_n && !m.col && !m.wr && !m.ack;
      e_err   = m.col && !rx_valid && (m.idle == TIMEOUT - 1);
      chk("ready", ready, e_ready);
      chk("rx_read", rx_read, m.col && rx_valid);
      chk("dmi_valid", dmi_valid, m.wr);
      chk("error", error, e_err);
      if (m.wr) begin
        chk("dmi_addr", dmi_address, m.addr);
        chk("dmi_data", dmi_data, m.word[40:0]);
      end
      c_cyc++;
      if (dmi_valid) begin
        c_valid++;
        last_data = dmi_data;
        last_addr = dmi_address;
      end
      if (!ready) c_rdy_low++;
      if (error) begin
        c_err++;
        c_err_cyc = c_cyc;
      end
      if (rx_read) begin
        c_rxread++;
        c_last_rx = c_cyc;
      end
      n = m;
      if (rst_n) begin
        if (e_ready && valid) begin
          if (command == CMD_WRITE) begin
            n.col  = 1'b1;
            n.got  = 0;
            n.idle = 0;
            n.word = '0;
            n.addr = address;
          end else if (command == CMD_RESET) begin
            n.ack  = 1'b1;
            n.word = '0;
            n.addr = ADDR_IDCODE;
          end
        end else if (m.col) begin
          if (rx_valid) begin
            n.word[8*m.got +: 8] = rx_data;
            n.got  = m.got + 1;
            n.idle = 0;
            if (n.got == NBYTES) begin
              n.col = 1'b0;
              n.wr  = 1'b1;
            end
          end else if (m.idle == TIMEOUT - 1) begin
            n.col = 1'b0;
            n.ack = 1'b1;
          end else begin
            n.idle = m.idle + 1;
          end
        end else if (m.wr) begin
          if (dmi_ready) begin
            n.wr  = 1'b0;
            n.ack = 1'b1;
          end
        end else if (m.ack) begin
          n.ack = 1'b0;
        end
      end
      @(posedge clk or negedge rst_n);
      if (!rst_n) m = reset_model();
      else m = n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [4:0] adr);
    valid   = 1'b1;
    command = cmd;
    address = adr;
    tick();
    valid   = 1'b0;
  endtask

  // Bytes go out little-endian from w, with `gap` idle cycles before each one
  task automatic send_payload(input logic [47:0] w, input int gap, input int count);
    for (int i = 0; i < count; i++) begin
      rx_valid = 1'b0;
      repeat (gap) tick();
      rx_valid = 1'b1;
      rx_data  = w[8*i +: 8];
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (ready) break;
      tick();
    end
    chk(name, ready, 1'b1);
  endtask

  initial begin
    int s_valid;
    int s_rdy;
    int s_err;
    int s_rx;

    rst_n     = 1'b0;
    valid     = 1'b0;
    command   = '0;
    address   = '0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    dmi_ready = 1'b0;
    fork
      compare_loop();
    join_none

    // Reset values
    repeat (3) tick();
    chk("rst_ready", ready, 1'b0);
    chk("rst_addr", dmi_address, ADDR_IDCODE);
    chk("rst_data", dmi_data, 41'h0);
    chk("rst_dmi_valid", dmi_valid, 1'b0);
    chk("rst_error", error, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", ready, 1'b1);

    // Back-to-back write, TAP always ready
    dmi_ready = 1'b1;
    s_valid = c_valid; s_rdy = c_rdy_low;
    issue(CMD_WRITE, 5'h11);
    send_payload(48'hFF_05_04_03_02_01, 0, 6);
    wait_idle(10, "t1_idle");
    chk("t1_valid_cycles", c_valid - s_valid, 1);
    chk("t1_ready_low", c_rdy_low - s_rdy, NBYTES + 2);
    chk("t1_data", last_data, 41'h1_05_04_03_02_01);
    chk("t1_addr", last_addr, 5'h11);

    // Gapped bytes, TAP stalls 4 cycles
    dmi_ready = 1'b0;
    s_valid = c_valid; s_rx = c_rxread;
    issue(CMD_WRITE, 5'h11);
    send_payload(48'hFF_05_04_03_02_01, 3, 6);
    repeat (4) tick();
    dmi_ready = 1'b1;
    tick();
    wait_idle(10, "t2_idle");
    chk("t2_valid_cycles", c_valid - s_valid, 5);
    chk("t2_rx_reads", c_rxread - s_rx, 6);
    chk("t2_data", last_data, 41'h1_05_04_03_02_01);

    // Stall after two bytes until the byte timeout aborts
    s_valid = c_valid; s_err = c_err;
    issue(CMD_WRITE, 5'h07);
    send_payload(48'h0000_0000_BBAA, 0, 2);
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      if (c_err != s_err) break;
      tick();
    end
    wait_idle(5, "t3_idle");
    chk("t3_err_pulses", c_err - s_err, 1);
    chk("t3_no_write", c_valid - s_valid, 0);
    chk("t3_err_delay", c_err_cyc - c_last_rx, TIMEOUT);

    // Normal write right after the abort
    s_valid = c_valid;
    issue(CMD_WRITE, 5'h0A);
    send_payload(48'hA5_A4_A3_A2_A1_A0, 0, 6);
    wait_idle(10, "t3b_idle");
    chk("t3b_valid_cycles", c_valid - s_valid, 1);
    chk("t3b_data", last_data, 41'h1_A4_A3_A2_A1_A0);
    chk("t3b_addr", last_addr, 5'h0A);

    // Reset command
    s_valid = c_valid; s_rdy = c_rdy_low;
    issue(CMD_RESET, 5'h10);
    wait_idle(5, "t4_idle");
    chk("t4_no_write", c_valid - s_valid, 0);
    chk("t4_ready_low", c_rdy_low - s_rdy, 1);
    chk("t4_data", dmi_data, 41'h0);
    chk("t4_addr", dmi_address, ADDR_IDCODE);

    // RX bytes in idle and on the acceptance cycle; unknown command
    s_rx = c_rxread; s_rdy = c_rdy_low;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    tick();
    issue(CMD_OTHER, 5'h04);
    tick();
    chk("t5_idle_rx_read", c_rxread - s_rx, 0);
    chk("t5_other_ready_low", c_rdy_low - s_rdy, 0);
    chk("t5_other_ready", ready, 1'b1);
    s_valid = c_valid; s_rx = c_rxread;
    valid   = 1'b1;
    command = CMD_WRITE;
    address = 5'h15;
    rx_data = 8'h77;
    #1;
    chk("t5_accept_rx_read", rx_read, 1'b0);
    tick();
    valid = 1'b0;
    tick();
    send_payload(48'h00_15_14_13_12_11, 0, 5);
    wait_idle(10, "t5_idle");
    chk("t5_rx_reads", c_rxread - s_rx, 6);
    chk("t5_valid_cycles", c_valid - s_valid, 1);
    chk("t5_data", last_data, 41'h1_14_13_12_11_77);
    chk("t5_addr", last_addr, 5'h15);

    // Asynchronous reset after three payload bytes
    s_valid = c_valid;
    issue(CMD_WRITE, 5'h03);
    send_payload(48'h0000_000C_0B0A, 0, 3);
    rx_valid = 1'b1;
    rx_data  = 8'h0D;
    #1;
    chk("t6_pre_rx_read", rx_read, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ready", ready, 1'b0);
    chk("t6_async_rx_read", rx_read, 1'b0);
    chk("t6_async_dmi_valid", dmi_valid, 1'b0);
    chk("t6_async_error", error, 1'b0);
    chk("t6_async_data", dmi_data, 41'h0);
    chk("t6_async_addr", dmi_address, ADDR_IDCODE);
    rx_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle(3, "t6_idle");
    repeat (NBYTES + 4) tick();
    chk("t6_no_write", c_valid - s_valid, 0);
    chk("t6_ready", ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
